// File: rtl/cache_way_ctl_if.sv
// ----------------------------------------------------------------------------
// cache_way_ctl_if
//   Bundle of all non-clock signals between the cache controller and one
//   cache way (cache_way_ctl).
//
//   master : the cache controller. It drives the lookup/write request, the
//            flush request and wb_ready.
//   slave  : the cache way. It drives the lookup status, the line data, the
//            busy/flush_done flags and the walker writeback request.
//
//   Writeback handshake: the way raises wb_valid together with wb_line_addr
//   and wb_data and keeps all three stable until it samples wb_ready high on
//   a rising clk edge. That edge is the transfer. wb_valid drops on the
//   following cycle. wb_ready has no effect while wb_valid is low.
// ----------------------------------------------------------------------------
interface cache_way_ctl_if #(
    parameter int CACHE_ENTRY = 14,
    parameter int ADDR_W      = 23,
    parameter int WORDS       = 4,
    parameter int WORD_W      = 32
);
    localparam int TAG_W  = ADDR_W - CACHE_ENTRY;
    localparam int BYTES  = WORD_W / 8;
    localparam int LINE_W = WORDS * WORD_W;

    // Lookup / write request
    logic [CACHE_ENTRY-1:0] entry;
    logic [TAG_W-1:0]       o_tag;
    logic [LINE_W-1:0]      writedata;
    logic [BYTES-1:0]       byte_en;
    logic [WORDS-1:0]       word_en;
    logic                   write;
    logic                   read_miss;

    // Lookup response
    logic [LINE_W-1:0]      readdata;
    logic [ADDR_W-1:0]      wb_addr;
    logic                   hit;
    logic                   modify;
    logic                   miss;
    logic                   valid;

    // Maintenance walk control
    logic                   flush_req;
    logic                   flush_inv;
    logic                   busy;
    logic                   flush_done;

    // Walker writeback port
    logic                   wb_valid;
    logic                   wb_ready;
    logic [ADDR_W-1:0]      wb_line_addr;
    logic [LINE_W-1:0]      wb_data;

    modport master (
        output entry, o_tag, writedata, byte_en, word_en, write, read_miss,
        output flush_req, flush_inv, wb_ready,
        input  readdata, wb_addr, hit, modify, miss, valid,
        input  busy, flush_done, wb_valid, wb_line_addr, wb_data
    );

    modport slave (
        input  entry, o_tag, writedata, byte_en, word_en, write, read_miss,
        input  flush_req, flush_inv, wb_ready,
        output readdata, wb_addr, hit, modify, miss, valid,
        output busy, flush_done, wb_valid, wb_line_addr, wb_data
    );
endinterface

// File: rtl/cache_way_ctl.sv
// ----------------------------------------------------------------------------
// cache_way_ctl
//   One way of the set-associative data cache: tag/valid/dirty SRAM, byte-lane
//   data SRAM and hit/modify/miss classification. After reset a hardware
//   sweep clears every tag word. On request, a walker visits every line,
//   writes dirty lines back over the wb_* ready/valid port and optionally
//   invalidates lines.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   bus        : cache_way_ctl_if.slave (request, lookup status, walk control,
//                writeback port)
//   dbg_state  : current FSM state (state_e encoding)
//
// SRAM behaviour: synchronous write, registered read, 1 cycle of read
// latency. A read and a write to the same address in the same cycle return
// the old contents. Tag word layout is {dirty, valid, tag}.
// ----------------------------------------------------------------------------
module cache_way_ctl #(
    parameter int CACHE_ENTRY = 14,
    parameter int ADDR_W      = 23,
    parameter int WORDS       = 4,
    parameter int WORD_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_way_ctl_if.slave      bus,
    output logic [2:0]          dbg_state
);
    localparam int TAG_W  = ADDR_W - CACHE_ENTRY;
    localparam int BYTES  = WORD_W / 8;
    localparam int LINE_W = WORDS * WORD_W;
    localparam int TW_W   = TAG_W + 2;
    localparam int DEPTH  = 1 << CACHE_ENTRY;
    localparam logic [CACHE_ENTRY-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        F_RD  = 3'd2,
        F_CHK = 3'd3,
        F_WB  = 3'd4,
        F_NXT = 3'd5
    } state_e;

    // Control registers
    state_e                 state_q, state_d;
    logic [CACHE_ENTRY-1:0] idx_q, idx_d;
    logic                   inv_q, inv_d;
    logic                   pend_q, pend_d;
    logic                   flush_done_q, flush_done_d;

    // SRAM read registers
    logic [CACHE_ENTRY-1:0] rd_addr_q, rd_addr_d;
    logic [TW_W-1:0]        tag_rd_q, tag_rd_d;
    logic [LINE_W-1:0]      data_rd_q, data_rd_d;

    // SRAM arrays
    logic [TW_W-1:0]        tag_mem  [DEPTH];
    logic [LINE_W-1:0]      data_mem [DEPTH];

    // SRAM write controls
    logic                   tag_we;
    logic [CACHE_ENTRY-1:0] tag_waddr;
    logic [TW_W-1:0]        tag_wdata;
    logic                   data_we;

    // Stored tag word of the entry read in the previous cycle
    logic                   st_dirty;
    logic                   st_valid;
    logic [TAG_W-1:0]       st_tag;
    logic                   tag_eq;
    logic                   raw_hit;
    logic                   raw_modify;
    logic                   raw_miss;
    logic                   busy_w;

    assign {st_dirty, st_valid, st_tag} = tag_rd_q;
    assign tag_eq     = (st_tag == bus.o_tag);
    assign raw_hit    = st_valid && tag_eq;
    assign raw_modify = st_valid && !tag_eq && st_dirty;
    assign raw_miss   = !st_valid || (!tag_eq && !st_dirty);

    assign busy_w = (state_q != IDLE);

    // Lookup status is meaningless while a sweep or walk owns the SRAMs.
    assign bus.hit    = !busy_w && raw_hit;
    assign bus.modify = !busy_w && raw_modify;
    assign bus.miss   = !busy_w && raw_miss;
    assign bus.valid  = !busy_w && st_valid;

    assign bus.readdata     = data_rd_q;
    assign bus.wb_addr      = {st_tag, rd_addr_q};
    assign bus.busy         = busy_w;
    assign bus.flush_done   = flush_done_q;
    assign bus.wb_valid     = (state_q == F_WB);
    assign bus.wb_line_addr = {st_tag, idx_q};
    assign bus.wb_data      = data_rd_q;

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Read port. The controller addresses the SRAMs in IDLE; the sweep and
    // walker address them with the index counter otherwise. The read
    // registers are frozen in F_WB so the offered address/data cannot move
    // while waiting for wb_ready.
    // ------------------------------------------------------------------
    always_comb begin
        rd_addr_d = (state_q == IDLE) ? bus.entry : idx_q;
        tag_rd_d  = tag_rd_q;
        data_rd_d = data_rd_q;
        if (state_q != F_WB) begin
            tag_rd_d  = tag_mem[rd_addr_d];
            data_rd_d = data_mem[rd_addr_d];
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and SRAM write control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        inv_d        = inv_q;
        pend_d       = pend_q;
        flush_done_d = 1'b0;
        tag_we       = 1'b0;
        tag_waddr    = idx_q;
        tag_wdata    = '0;
        data_we      = 1'b0;

        case (state_q)
            INIT: begin
                tag_we    = 1'b1;
                tag_wdata = '0;
                // A flush requested during the sweep runs as soon as it ends.
                if (bus.flush_req) begin
                    pend_d = 1'b1;
                    inv_d  = bus.flush_inv;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = pend_d ? F_RD : IDLE;
                    pend_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            IDLE: begin
                tag_waddr = bus.entry;
                if (bus.write) begin
                    tag_we  = 1'b1;
                    data_we = 1'b1;
                    if (bus.read_miss) begin
                        // Refill: line arrives clean from memory.
                        tag_wdata = {1'b0, 1'b1, bus.o_tag};
                    end else if (raw_modify || raw_miss) begin
                        // Store that allocates over a victim.
                        tag_wdata = {1'b1, 1'b1, bus.o_tag};
                    end else begin
                        // Store hit: keep the tag, mark the line dirty.
                        tag_wdata = {1'b1, 1'b1, st_tag};
                    end
                end
                if (bus.flush_req) begin
                    state_d = F_RD;
                    inv_d   = bus.flush_inv;
                    idx_d   = '0;
                end
            end

            F_RD: begin
                state_d = F_CHK;
            end

            F_CHK: begin
                if (st_valid && st_dirty) begin
                    state_d = F_WB;
                end else begin
                    if (st_valid && inv_q) begin
                        tag_we    = 1'b1;
                        tag_wdata = {1'b0, 1'b0, st_tag};
                    end
                    state_d = F_NXT;
                end
            end

            F_WB: begin
                if (bus.wb_ready) begin
                    tag_we    = 1'b1;
                    tag_wdata = {1'b0, !inv_q, st_tag};
                    state_d   = F_NXT;
                end
            end

            F_NXT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = F_RD;
                end
            end

            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase

        // No SRAM writes while reset is held; the sweep will clear tags anyway.
        if (!rst_n) begin
            tag_we  = 1'b0;
            data_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= INIT;
            idx_q        <= '0;
            inv_q        <= 1'b0;
            pend_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            inv_q        <= inv_d;
            pend_q       <= pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM arrays and read registers (no reset: contents are don't-care
    // until written, tags are cleared by the sweep)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rd_addr_q <= rd_addr_d;
        tag_rd_q  <= tag_rd_d;
        data_rd_q <= data_rd_d;
        if (tag_we) begin
            tag_mem[tag_waddr] <= tag_wdata;
        end
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (data_we && bus.word_en[w] && bus.byte_en[b]) begin
                    data_mem[bus.entry][w*WORD_W + b*8 +: 8] <=
                        bus.writedata[w*WORD_W + b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_way_ctl.sv
// ----------------------------------------------------------------------------
// tb_cache_way_ctl
//   Bench for cache_way_ctl with a 16-line way (CACHE_ENTRY=4), 8-bit tags
//   and 128-bit lines. A reference model (per-line tag/valid/dirty/data
//   arrays plus a known-byte mask) predicts lookup results and writeback
//   transactions; predictions are queued and popped by monitors on the
//   falling edge.
// ----------------------------------------------------------------------------
module tb_cache_way_ctl;
    localparam int CE     = 4;
    localparam int ADDR_W = 12;
    localparam int WORDS  = 4;
    localparam int WORD_W = 32;
    localparam int TAG_W  = ADDR_W - CE;
    localparam int BYTES  = WORD_W / 8;
    localparam int LINE_W = WORDS * WORD_W;
    localparam int N      = 1 << CE;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    cache_way_ctl_if #(.CACHE_ENTRY(CE), .ADDR_W(ADDR_W), .WORDS(WORDS), .WORD_W(WORD_W)) bus ();

    cache_way_ctl #(.CACHE_ENTRY(CE), .ADDR_W(ADDR_W), .WORDS(WORDS), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit lk_sample = 1'b0;
    bit ready_hold = 1'b0;
    int wb_delay = -1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TAG_W-1:0]  m_tag   [N];
    logic              m_v     [N];
    logic              m_d     [N];
    logic [LINE_W-1:0] m_data  [N];
    logic [LINE_W-1:0] m_known [N];

    typedef struct packed {
        logic              hit;
        logic              modify;
        logic              miss;
        logic              valid;
        logic [ADDR_W-1:0] wb_addr;
        logic [LINE_W-1:0] data;
        logic [LINE_W-1:0] mask;
    } lk_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic [LINE_W-1:0] mask;
    } wb_t;

    lk_t lk_exp_q[$];
    wb_t wb_exp_q[$];

    // {hit, modify, miss} from the classification rules
    function automatic logic [2:0] status(input int e, input logic [TAG_W-1:0] t);
        if (!m_v[e])       return 3'b001;
        if (m_tag[e] == t) return 3'b100;
        if (m_d[e])        return 3'b010;
        return 3'b001;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic lookup(input int e, input logic [TAG_W-1:0] t);
        lk_t x;
        bus.entry = e[CE-1:0];
        bus.o_tag = t;
        bus.write = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        x = '0;
        {x.hit, x.modify, x.miss} = status(e, t);
        x.valid   = m_v[e];
        x.wb_addr = {m_tag[e], e[CE-1:0]};
        x.data    = m_data[e];
        x.mask    = m_v[e] ? m_known[e] : '0;
        lk_exp_q.push_back(x);
        lk_sample = 1'b1;
        @(posedge clk); #1;
        lk_sample = 1'b0;
    endtask

    task automatic do_write(input int e, input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d,
                            input logic [BYTES-1:0] be, input logic [WORDS-1:0] we, input logic rm);
        logic [2:0] st;
        bus.entry = e[CE-1:0];
        bus.o_tag = t;
        bus.write = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        bus.writedata = d;
        bus.byte_en   = be;
        bus.word_en   = we;
        bus.read_miss = rm;
        bus.write     = 1'b1;
        st = status(e, t);
        if (rm) begin
            m_tag[e] = t; m_v[e] = 1'b1; m_d[e] = 1'b0;
        end else if (st[1] || st[0]) begin
            m_tag[e] = t; m_v[e] = 1'b1; m_d[e] = 1'b1;
        end else begin
            m_v[e] = 1'b1; m_d[e] = 1'b1;
        end
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < BYTES; b++)
                if (we[w] && be[b]) begin
                    m_data[e][w*WORD_W + b*8 +: 8]  = d[w*WORD_W + b*8 +: 8];
                    m_known[e][w*WORD_W + b*8 +: 8] = 8'hFF;
                end
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic do_flush(input logic inv, input int delay);
        wb_t w;
        int  cyc;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_d[i]) begin
                w.addr = {m_tag[i], i[CE-1:0]};
                w.data = m_data[i];
                w.mask = m_known[i];
                wb_exp_q.push_back(w);
                m_d[i] = 1'b0;
                m_v[i] = !inv;
            end else if (m_v[i] && inv) begin
                m_v[i] = 1'b0;
            end
        end
        wb_delay      = delay;
        bus.flush_inv = inv;
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        check("flush_busy", bus.busy, 1'b1);
        cyc = 0;
        while (!bus.flush_done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("flush_done_seen", cyc < 5000, 1'b1);
        check("flush_done_not_busy", bus.busy, 1'b0);
        check("wb_queue_drained", wb_exp_q.size(), 0);
        @(posedge clk); #1;
        check("flush_done_pulse", bus.flush_done, 1'b0);
    endtask

    task automatic do_reset(input bit flush_in_init, input bit write_in_init);
        int cnt;
        int exp_busy;
        rst_n = 1'b0;
        bus.write = 1'b0;
        bus.flush_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        wb_exp_q.delete();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0; m_d[i] = 1'b0; m_tag[i] = '0;
        end
        check("rst_busy", bus.busy, 1'b1);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_flush_done", bus.flush_done, 1'b0);
        check("rst_lookup", {bus.hit, bus.modify, bus.miss, bus.valid}, 4'b0);
        check("rst_state", dbg_state, 3'd0);
        cnt = 0;
        while (bus.busy && cnt < 500) begin
            bus.flush_req = flush_in_init && (cnt == 2);
            bus.flush_inv = 1'b1;
            if (write_in_init) begin
                bus.entry = 4'd2; bus.o_tag = 8'h33; bus.read_miss = 1'b1;
                bus.byte_en = '1; bus.word_en = '1; bus.writedata = '1;
                bus.write = 1'b1;
            end
            @(posedge clk); #1;
            cnt++;
        end
        bus.write = 1'b0;
        bus.flush_req = 1'b0;
        // Sweep is one line per cycle; a walk over all-invalid lines costs
        // three cycles (read, check, next) per line.
        exp_busy = flush_in_init ? (N + 3 * N) : N;
        check("init_busy_cycles", cnt, exp_busy);
        check("init_flush_done", bus.flush_done, flush_in_init);
    endtask

    // ---------------- writeback ready driver ----------------
    initial begin
        int cnt;
        bit armed;
        bus.wb_ready = 1'b0;
        armed = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (ready_hold || !rst_n) begin
                bus.wb_ready = 1'b0;
                armed = 1'b0;
            end else if (bus.wb_valid) begin
                if (!armed) begin
                    armed = 1'b1;
                    cnt = (wb_delay < 0) ? $urandom_range(0, 4) : wb_delay;
                end
                if (cnt == 0) begin
                    bus.wb_ready = 1'b1;
                    armed = 1'b0;
                end else begin
                    bus.wb_ready = 1'b0;
                    cnt--;
                end
            end else begin
                // Stray ready pulses while nothing is offered must be ignored.
                bus.wb_ready = ($urandom_range(0, 3) == 0);
                armed = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        lk_t x;
        if (lk_sample) begin
            if (lk_exp_q.size() == 0) begin
                check("lk_queue_underflow", 1'b1, 1'b0);
            end else begin
                x = lk_exp_q.pop_front();
                check("lk_busy", bus.busy, 1'b0);
                check("lk_hit", bus.hit, x.hit);
                check("lk_modify", bus.modify, x.modify);
                check("lk_miss", bus.miss, x.miss);
                check("lk_valid", bus.valid, x.valid);
                if (x.valid) check("lk_wb_addr", bus.wb_addr, x.wb_addr);
                check("lk_readdata", bus.readdata & x.mask, x.data & x.mask);
            end
        end
    end

    logic              prev_pending = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [LINE_W-1:0] prev_data;

    always @(negedge clk) begin
        wb_t x;
        if (!rst_n || !bus.wb_valid) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("wb_addr_stable", bus.wb_line_addr, prev_addr);
                check("wb_data_stable", bus.wb_data, prev_data);
            end
            if (bus.wb_ready) begin
                if (wb_exp_q.size() == 0) begin
                    check("wb_unexpected", 1'b1, 1'b0);
                end else begin
                    x = wb_exp_q.pop_front();
                    check("wb_line_addr", bus.wb_line_addr, x.addr);
                    check("wb_data", bus.wb_data & x.mask, x.data & x.mask);
                end
            end
            prev_pending = !bus.wb_ready;
            prev_addr = bus.wb_line_addr;
            prev_data = bus.wb_data;
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (bus.busy)
                check("busy_lookup_zero", {bus.hit, bus.modify, bus.miss, bus.valid}, 4'b0);
            else
                check("one_hot_status", $countones({bus.hit, bus.modify, bus.miss}), 1);
            if (bus.flush_done) check("done_with_busy", bus.busy, 1'b0);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [LINE_W-1:0] d;
        logic [TAG_W-1:0]  t;
        int op;
        int e;
        int cyc;

        bus.entry = '0; bus.o_tag = '0; bus.writedata = '0; bus.byte_en = '0;
        bus.word_en = '0; bus.write = 1'b0; bus.read_miss = 1'b0;
        bus.flush_req = 1'b0; bus.flush_inv = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0; m_known[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Init sweep, with a write held during it that must be ignored
        do_reset(1'b0, 1'b1);
        lookup(0, 8'h00);
        lookup(2, 8'h33);
        lookup(5, 8'h12);
        lookup(15, 8'h00);

        // Refill and hit
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_write(3, 8'h12, d, '1, '1, 1'b1);
        lookup(3, 8'h12);
        lookup(3, 8'h13);

        // Store one byte of word 1, then victim lookup
        d = 128'h0;
        d[39:32] = 8'hAA;
        do_write(3, 8'h12, d, 4'b0001, 4'b0010, 1'b0);
        lookup(3, 8'h12);
        lookup(3, 8'h13);

        // Two dirty lines, flush without invalidate, slow wb_ready
        do_write(9, 8'h5A, {$urandom, $urandom, $urandom, $urandom}, '1, '1, 1'b1);
        do_write(9, 8'h5A, {$urandom, $urandom, $urandom, $urandom}, 4'b1100, 4'b1001, 1'b0);
        do_flush(1'b0, 3);
        lookup(3, 8'h12);
        lookup(3, 8'h13);
        lookup(9, 8'h5A);

        // One dirty and one clean line, flush with invalidate
        do_write(3, 8'h12, {$urandom, $urandom, $urandom, $urandom}, 4'b0101, 4'b0001, 1'b0);
        do_flush(1'b1, 2);
        for (int i = 0; i < N; i++) lookup(i, 8'h12);

        // Randomized traffic
        repeat (80) begin
            op = $urandom_range(0, 9);
            e  = $urandom_range(0, N - 1);
            t  = TAG_W'($urandom_range(0, 3));
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (op < 5) begin
                if ($urandom_range(0, 1) == 1)
                    do_write(e, t, d, '1, '1, 1'b1);
                else
                    do_write(e, t, d, BYTES'($urandom), WORDS'($urandom), 1'b0);
            end else if (op < 9) begin
                lookup(e, t);
            end else begin
                do_flush(1'(($urandom_range(0, 1))), -1);
            end
        end
        do_flush(1'b0, -1);
        for (int i = 0; i < N; i += 3) lookup(i, m_tag[i]);

        // Reset while a writeback is stalled
        ready_hold = 1'b1;
        do_write(6, 8'h01, {$urandom, $urandom, $urandom, $urandom}, '1, '1, 1'b0);
        bus.flush_inv = 1'b0;
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        cyc = 0;
        while (!bus.wb_valid && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_wb_valid_seen", cyc < 500, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("stall_wb_valid_held", bus.wb_valid, 1'b1);
        do_reset(1'b0, 1'b0);
        ready_hold = 1'b0;
        for (int i = 0; i < N; i++) lookup(i, 8'h01);

        // Flush requested during the sweep starts right after it
        do_reset(1'b1, 1'b0);
        lookup(6, 8'h01);

        check("lk_queue_empty", lk_exp_q.size(), 0);
        check("wb_queue_empty", wb_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
